// File: rtl/input_port_reader_pkg.sv
// Shared constants and address-decode helper for the memory-mapped input port.
// Register offsets are relative to the block's base address.
package input_port_reader_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [31:0] OFF_SW   = 32'h0000_0000;
  localparam logic [31:0] OFF_BTN  = 32'h0000_0004;
  localparam logic [31:0] OFF_EDGE = 32'h0000_0008;
  localparam logic [31:0] OFF_CNT  = 32'h0000_000C;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    REG_SW   = 2'd0,
    REG_BTN  = 2'd1,
    REG_EDGE = 2'd2,
    REG_CNT  = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  function automatic reg_dec_t decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    reg_dec_t dec;
    dec.hit = 1'b1;
    dec.sel = REG_SW;
    if (addr == base + OFF_SW)        dec.sel = REG_SW;
    else if (addr == base + OFF_BTN)  dec.sel = REG_BTN;
    else if (addr == base + OFF_EDGE) dec.sel = REG_EDGE;
    else if (addr == base + OFF_CNT)  dec.sel = REG_CNT;
    else                              dec.hit = 1'b0;
    return dec;
  endfunction

endpackage

// File: rtl/input_port_reader_debouncer.sv
// Single-bit 2-flop synchroniser followed by a consecutive-cycle debounce filter.
// rise_o is high in the cycle before the accepted level steps from 0 to 1.
module input_debouncer #(
  parameter logic [15:0] DEB_CYCLES = 16'd20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        level_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        differ;
  logic        accept;

  // cnt_q holds how many consecutive differing cycles have already been seen,
  // so the level is accepted on the DEB_CYCLES-th one.
  always_comb begin
    differ  = (sync2_q != level_q);
    accept  = differ && (cnt_q == DEB_CYCLES - 16'd1);
    level_d = accept ? sync2_q : level_q;
    cnt_d   = (!differ || accept) ? 16'd0 : cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchroniser chain would collapse with blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = accept && sync2_q;

endmodule

// File: rtl/input_port_reader.sv
// Memory-mapped switch/button reader: debounced levels, sticky press flags
// and a saturating press counter, read combinationally on deviceData.
module input_port_reader
  import input_port_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1010,
  parameter int          NUM_SW     = 8,
  parameter int          NUM_BTN    = 4,
  parameter logic [15:0] DEB_CYCLES = 16'd20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        dataIn,
  input  logic               memWrite,
  input  logic               memRead,
  input  logic [NUM_SW-1:0]  switches,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [31:0]        deviceData
);

  localparam int NUM_IN = NUM_SW + NUM_BTN;

  logic [NUM_IN-1:0]  raw_all;
  logic [NUM_IN-1:0]  level_all;
  logic [NUM_IN-1:0]  rise_all;
  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               wr_edge;
  logic               wr_cnt;
  logic [NUM_BTN-1:0] w1c_mask;
  logic [CNT_W:0]     presses;
  logic [CNT_W:0]     cnt_base;
  logic [CNT_W:0]     cnt_sum;
  reg_dec_t           rd_dec;

  // Switch rise pulses and the unused upper store-data bits have no consumer.
  logic rise_unused;
  logic data_unused;
  assign rise_unused = ^rise_all[NUM_SW-1:0];
  assign data_unused = ^dataIn;

  assign raw_all = {buttons, switches};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    input_debouncer #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_all[i]),
      .level_o(level_all[i]),
      .rise_o (rise_all[i])
    );
  end

  assign sw_level  = level_all[NUM_SW-1:0];
  assign btn_level = level_all[NUM_IN-1:NUM_SW];
  assign btn_rise  = rise_all[NUM_IN-1:NUM_SW];

  assign wr_edge = memWrite && (address == BASE_ADDR + OFF_EDGE);
  assign wr_cnt  = memWrite && (address == BASE_ADDR + OFF_CNT);

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    presses = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      presses = presses + {{CNT_W{1'b0}}, btn_rise[i]};
    end
    // The write clears first; presses landing in the same cycle still count.
    cnt_base = wr_cnt ? '0 : {1'b0, cnt_q};
    cnt_sum  = cnt_base + presses;
    cnt_d    = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];

    w1c_mask = wr_edge ? dataIn[NUM_BTN-1:0] : '0;
    edge_d   = (edge_q & ~w1c_mask) | btn_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      cnt_q  <= '0;
    end else begin
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read path reflects pre-edge register values, so a same-cycle store is
  // not visible until the following cycle.
  always_comb begin
    rd_dec     = decode_addr(address, BASE_ADDR);
    deviceData = '0;
    if (memRead && rd_dec.hit) begin
      unique case (rd_dec.sel)
        REG_SW:   deviceData[NUM_SW-1:0]  = sw_level;
        REG_BTN:  deviceData[NUM_BTN-1:0] = btn_level;
        REG_EDGE: deviceData[NUM_BTN-1:0] = edge_q;
        REG_CNT:  deviceData[CNT_W-1:0]   = cnt_q;
        default:  deviceData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_reader.sv
// Directed self-checking bench for input_port_reader with DEB_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_input_port_reader;

  localparam logic [31:0] BASE = 32'h0000_1010;
  localparam logic [31:0] A_SW   = 32'h0000_1010;
  localparam logic [31:0] A_BTN  = 32'h0000_1014;
  localparam logic [31:0] A_EDGE = 32'h0000_1018;
  localparam logic [31:0] A_CNT  = 32'h0000_101C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic        memWrite;
  logic        memRead;
  logic [7:0]  switches;
  logic [3:0]  buttons;
  logic [31:0] deviceData;

  int n_cmp = 0;
  int n_bad = 0;

  input_port_reader #(
    .BASE_ADDR (BASE),
    .NUM_SW    (8),
    .NUM_BTN   (4),
    .DEB_CYCLES(16'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .dataIn    (dataIn),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .switches  (switches),
    .buttons   (buttons),
    .deviceData(deviceData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    memRead = 1'b1;
    #1;
    check(tag, deviceData, exp);
    memRead = 1'b0;
    address = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    address  = addr;
    dataIn   = data;
    memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
    address  = '0;
    dataIn   = '0;
  endtask

  initial begin
    rst = 1'b1; address = '0; dataIn = '0; memWrite = 1'b0; memRead = 1'b0;
    switches = 8'h00; buttons = 4'h0;

    // Reset and idle
    tick(2);
    rst = 1'b0;
    rd_chk("rst_sw",   A_SW,   32'h0);
    rd_chk("rst_btn",  A_BTN,  32'h0);
    rd_chk("rst_edge", A_EDGE, 32'h0);
    rd_chk("rst_cnt",  A_CNT,  32'h0);
    rd_chk("unmapped", 32'h0000_1020, 32'h0);

    // Switch debounce: 2 sync + 4 stable cycles
    switches = 8'hA5;
    tick(5);
    rd_chk("sw_cyc5", A_SW, 32'h0);
    tick();
    rd_chk("sw_cyc6", A_SW, 32'hA5);
    address = A_SW; memRead = 1'b0; #1;
    check("no_read_zero", deviceData, 32'h0);
    address = '0;
    wr(A_SW, 32'hFFFF_FFFF);
    rd_chk("sw_write_ignored", A_SW, 32'hA5);

    // 3-cycle glitch on bit0 is too short to be accepted
    switches = 8'hA4;
    tick(3);
    switches = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      tick();
      rd_chk($sformatf("sw_glitch_%0d", i), A_SW, 32'hA5);
    end

    // Button 2 press, then a 2-cycle bounce
    buttons = 4'b0100;
    tick(10);
    rd_chk("btn2_level", A_BTN,  32'h4);
    rd_chk("btn2_edge",  A_EDGE, 32'h4);
    rd_chk("btn2_cnt",   A_CNT,  32'h1);
    buttons = 4'b0000;
    tick(2);
    buttons = 4'b0100;
    tick(8);
    rd_chk("bounce_cnt",  A_CNT,  32'h1);
    rd_chk("bounce_edge", A_EDGE, 32'h4);

    // W1C clears bit 2
    wr(A_EDGE, 32'h4);
    rd_chk("w1c_edge", A_EDGE, 32'h0);

    // Button 1 accepted edge lands on the same edge as a W1C of bit 1
    buttons = 4'b0110;
    tick(5);
    rd_chk("pre_setwins_edge", A_EDGE, 32'h0);
    wr(A_EDGE, 32'h2);
    rd_chk("setwins_edge", A_EDGE, 32'h2);
    rd_chk("setwins_cnt",  A_CNT,  32'h2);

    // Button 0 press coincides with a CNT clear: clear then add
    buttons = 4'b0111;
    tick(5);
    wr(A_CNT, 32'hDEAD_BEEF);
    rd_chk("clr_inc_cnt",  A_CNT,  32'h1);
    rd_chk("clr_inc_edge", A_EDGE, 32'h3);

    // Read and write EDGE in the same cycle: read sees pre-write value
    address = A_EDGE; dataIn = 32'h1; memWrite = 1'b1; memRead = 1'b1;
    #1;
    check("rw_same_cycle", deviceData, 32'h3);
    tick();
    memWrite = 1'b0; memRead = 1'b0; address = '0; dataIn = '0;
    rd_chk("rw_after", A_EDGE, 32'h2);

    buttons = 4'b0000;
    tick(8);
    rd_chk("release_btn", A_BTN, 32'h0);

    // Saturation: 0xFFFD + 4 simultaneous presses clamps at 0xFFFF
    force dut.cnt_q = 16'hFFFD;
    #1;
    release dut.cnt_q;
    buttons = 4'b1111;
    tick(6);
    rd_chk("sat_multi_cnt", A_CNT,  32'hFFFF);
    rd_chk("sat_multi_edge", A_EDGE, 32'hF);
    buttons = 4'b0000;
    tick(8);
    buttons = 4'b1000;
    tick(8);
    rd_chk("sat_hold_cnt", A_CNT, 32'hFFFF);
    wr(A_CNT, 32'h0);
    rd_chk("cnt_clear", A_CNT, 32'h0);
    buttons = 4'b0000;
    tick(8);

    // Reset three cycles into a debounce; button 0 held through reset
    switches = 8'h3C;
    buttons  = 4'b0001;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("mid_rst_sw",   A_SW,   32'h0);
    rd_chk("mid_rst_edge", A_EDGE, 32'h0);
    rd_chk("mid_rst_cnt",  A_CNT,  32'h0);
    tick(5);
    rd_chk("post_rst_sw5",   A_SW,   32'h0);
    rd_chk("post_rst_edge5", A_EDGE, 32'h0);
    tick();
    rd_chk("post_rst_sw6",   A_SW,   32'h3C);
    rd_chk("post_rst_btn6",  A_BTN,  32'h1);
    rd_chk("post_rst_edge6", A_EDGE, 32'h1);
    rd_chk("post_rst_cnt6",  A_CNT,  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
